// File: rtl/esp_dma64_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : esp_dma64_mem_responder                                       |
// | Purpose  : Memory-side responder for the 64-bit ESP DMA interface.       |
// |            Serves accelerator read/write DMA requests from an internal   |
// |            word-addressed memory of 2**ADDR_W 64-bit words, with a       |
// |            backdoor port for preloading and inspecting memory.           |
// | Ports    : clk / rst (async, active-low)                                 |
// |            dma_read_ctrl_*   : read request (index, length, size, user)  |
// |            dma_read_chnl_*   : registered read beat stream               |
// |            dma_write_ctrl_*  : write request (index, length, size, user) |
// |            dma_write_chnl_*  : write beat stream, registered ready       |
// |            bd_*              : backdoor access, read data one cycle late |
// |            err_size          : sticky illegal-size flag                  |
// |            rd_beats/wr_beats : wrapping beat counters                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module esp_dma64_mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              dma_read_ctrl_valid,
  output logic              dma_read_ctrl_ready,
  input  logic [31:0]       dma_read_ctrl_data_index,
  input  logic [31:0]       dma_read_ctrl_data_length,
  input  logic [2:0]        dma_read_ctrl_data_size,
  input  logic [5:0]        dma_read_ctrl_data_user,
  output logic              dma_read_chnl_valid,
  input  logic              dma_read_chnl_ready,
  output logic [63:0]       dma_read_chnl_data,

  input  logic              dma_write_ctrl_valid,
  output logic              dma_write_ctrl_ready,
  input  logic [31:0]       dma_write_ctrl_data_index,
  input  logic [31:0]       dma_write_ctrl_data_length,
  input  logic [2:0]        dma_write_ctrl_data_size,
  input  logic [5:0]        dma_write_ctrl_data_user,
  input  logic              dma_write_chnl_valid,
  output logic              dma_write_chnl_ready,
  input  logic [63:0]       dma_write_chnl_data,

  input  logic              bd_en,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [63:0]       bd_wdata,
  output logic [63:0]       bd_rdata,

  output logic              err_size,
  output logic [15:0]       rd_beats,
  output logic [15:0]       wr_beats
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [2:0] SIZE_64 = 3'b011;

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_STREAM = 1'b1} rd_state_t;
  typedef enum logic [0:0] {W_IDLE = 1'b0, W_STREAM = 1'b1} wr_state_t;

  logic [63:0] mem_q [DEPTH];

  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [31:0]       rd_rem_q,   rd_rem_d;
  logic              rd_valid_q, rd_valid_d;
  logic [63:0]       rd_data_q,  rd_data_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [31:0]       wr_rem_q,   wr_rem_d;
  logic              wr_ready_q, wr_ready_d;

  logic              err_q,      err_d;
  logic [15:0]       rd_cnt_q,   rd_cnt_d;
  logic [15:0]       wr_cnt_q,   wr_cnt_d;
  logic [63:0]       bd_rdata_q, bd_rdata_d;

  logic              rd_req_hs, wr_req_hs, rd_beat_hs, wr_beat_hs;
  logic [ADDR_W-1:0] rd_ptr_inc, wr_ptr_inc;

  // Request-side ready depends only on the state register.
  assign dma_read_ctrl_ready  = (rd_state_q == R_IDLE);
  assign dma_write_ctrl_ready = (wr_state_q == W_IDLE);

  assign rd_req_hs  = dma_read_ctrl_valid  & dma_read_ctrl_ready;
  assign wr_req_hs  = dma_write_ctrl_valid & dma_write_ctrl_ready;
  assign rd_beat_hs = rd_valid_q & dma_read_chnl_ready;
  assign wr_beat_hs = wr_ready_q & dma_write_chnl_valid;

  assign rd_ptr_inc = rd_ptr_q + 1'b1;
  assign wr_ptr_inc = wr_ptr_q + 1'b1;

  // Index bits above the memory width and the user field carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user,
                           dma_read_ctrl_data_index[31:ADDR_W],
                           dma_write_ctrl_data_index[31:ADDR_W]};

  // ---------------------------------------------------------------- read engine
  // The outgoing beat is a register loaded from memory at the handshake edge,
  // so a DMA write landing on the same word in that cycle is not observed.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_rem_d   = rd_rem_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req_hs && (dma_read_ctrl_data_length != 32'd0)) begin
          rd_ptr_d   = dma_read_ctrl_data_index[ADDR_W-1:0];
          rd_rem_d   = dma_read_ctrl_data_length;
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[dma_read_ctrl_data_index[ADDR_W-1:0]];
          rd_state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (rd_beat_hs) begin
          rd_ptr_d  = rd_ptr_inc;
          rd_rem_d  = rd_rem_q - 32'd1;
          rd_data_d = mem_q[rd_ptr_inc];
          if (rd_rem_q == 32'd1) begin
            rd_valid_d = 1'b0;
            rd_state_d = R_IDLE;
          end
        end
      end
      default: begin
        rd_valid_d = 1'b0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------- write engine
  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_rem_d   = wr_rem_q;
    wr_ready_d = wr_ready_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req_hs && (dma_write_ctrl_data_length != 32'd0)) begin
          wr_ptr_d   = dma_write_ctrl_data_index[ADDR_W-1:0];
          wr_rem_d   = dma_write_ctrl_data_length;
          wr_ready_d = 1'b1;
          wr_state_d = W_STREAM;
        end
      end
      W_STREAM: begin
        if (wr_beat_hs) begin
          wr_ptr_d = wr_ptr_inc;
          wr_rem_d = wr_rem_q - 32'd1;
          if (wr_rem_q == 32'd1) begin
            wr_ready_d = 1'b0;
            wr_state_d = W_IDLE;
          end
        end
      end
      default: begin
        wr_ready_d = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ status and backdoor
  always_comb begin
    err_d      = err_q
               | (rd_req_hs & (dma_read_ctrl_data_size  != SIZE_64))
               | (wr_req_hs & (dma_write_ctrl_data_size != SIZE_64));
    rd_cnt_d   = rd_cnt_q + {15'd0, rd_beat_hs};
    wr_cnt_d   = wr_cnt_q + {15'd0, wr_beat_hs};
    bd_rdata_d = bd_rdata_q;
    if (bd_en && !bd_we) begin
      bd_rdata_d = mem_q[bd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      rd_ptr_q   <= '0;
      rd_rem_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_state_q <= W_IDLE;
      wr_ptr_q   <= '0;
      wr_rem_q   <= '0;
      wr_ready_q <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      bd_rdata_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_rem_q   <= rd_rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_state_q <= wr_state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_rem_q   <= wr_rem_d;
      wr_ready_q <= wr_ready_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      bd_rdata_q <= bd_rdata_d;
    end
  end

  // Memory array is never reset. A DMA write beat takes priority over a
  // backdoor write to the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (bd_en && bd_we && !(wr_beat_hs && (bd_addr == wr_ptr_q))) begin
      mem_q[bd_addr] <= bd_wdata;
    end
    if (wr_beat_hs) begin
      mem_q[wr_ptr_q] <= dma_write_chnl_data;
    end
  end

  assign dma_read_chnl_valid  = rd_valid_q;
  assign dma_read_chnl_data   = rd_data_q;
  assign dma_write_chnl_ready = wr_ready_q;
  assign bd_rdata             = bd_rdata_q;
  assign err_size             = err_q;
  assign rd_beats             = rd_cnt_q;
  assign wr_beats             = wr_cnt_q;

endmodule
`default_nettype wire
